// File: rtl/if_stage_pc.sv
// Fetch-stage program counter and IF/ID pipeline register.
// Selects redirect/hold/increment PC and captures the fetched instruction.
module if_stage_pc #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      calcBranch,
    input  logic             PCSrc,
    input  logic             IF_ID_flush,
    input  logic             stall_IF,
    input  logic [31:0]      instr_IF,
    output logic [63:0]      instrAddr,
    output logic [31:0]      instr_ID,
    output logic [63:0]      currPC_reg_ID,
    output logic             valid_ID,
    output logic             misalignFault,
    output logic [CNT_W-1:0] redirectCount
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        pc_nxt;
    logic [31:0]        instr_nxt;
    logic [63:0]        cpc_nxt;
    logic               valid_nxt;
    logic               fault_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            instrAddr     <= RESET_PC;
            instr_ID      <= NOP_INSTR;
            currPC_reg_ID <= 64'h0;
            valid_ID      <= 1'b0;
            misalignFault <= 1'b0;
            redirectCount <= '0;
        end else begin
            state         <= state_nxt;
            instrAddr     <= pc_nxt;
            instr_ID      <= instr_nxt;
            currPC_reg_ID <= cpc_nxt;
            valid_ID      <= valid_nxt;
            misalignFault <= fault_nxt;
            redirectCount <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = instrAddr;
        instr_nxt = instr_ID;
        cpc_nxt   = currPC_reg_ID;
        valid_nxt = valid_ID;
        fault_nxt = misalignFault;
        cnt_nxt   = redirectCount;
        unique case (state)
            BOOT: begin
                state_nxt = RUN;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end
            RUN: begin
                // The branch in EX is older than the stalled fetch, so it wins.
                if (PCSrc) begin
                    pc_nxt = {calcBranch[63:2], 2'b00};
                    if (calcBranch[1:0] != 2'b00)
                        fault_nxt = 1'b1;
                    if (~&redirectCount)
                        cnt_nxt = redirectCount + CNT_W'(1);
                end else if (!stall_IF) begin
                    pc_nxt = instrAddr + 64'd4;
                end

                if (IF_ID_flush) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (!stall_IF) begin
                    instr_nxt = instr_IF;
                    cpc_nxt   = instrAddr;
                    valid_nxt = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

endmodule

// File: doc/if_stage_pc.md
Name: if_stage_pc

Overview:
- Fetch-stage PC and IF/ID pipeline register. It consumes the EX-stage branch outputs (calcBranch, PCSrc, IF_ID_flush).
- Each cycle it selects the next PC (redirect target, hold for stall, or PC+4), drives the instruction-memory address, and captures the fetched instruction plus its PC into the IF/ID register for ID.
- Also tracks fetch validity after reset, sticky misaligned-target fault, and a saturating taken-redirect counter.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, bubble encoding written to IF/ID on flush/invalid.
- CNT_W, 16, width of redirect counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- calcBranch  input  64  branch target from EX.
- PCSrc  input  1  1 = redirect PC to calcBranch.
- IF_ID_flush  input  1  1 = squash instruction entering IF/ID this edge.
- stall_IF  input  1  hazard-unit stall: hold PC and IF/ID.
- instr_IF  input  32  instruction-memory read data for instrAddr (combinational memory).
- instrAddr  output  64  current PC to instruction memory.
- instr_ID  output  32  IF/ID instruction.
- currPC_reg_ID  output  64  PC of instr_ID.
- valid_ID  output  1  instr_ID is a real fetched instruction.
- misalignFault  output  1  sticky: a redirect target had bits[1:0] != 0.
- redirectCount  output  CNT_W  number of accepted redirects, saturating.

Behaviour:
Reset (reset=0, asynchronous, any time including mid-stall or mid-redirect):
- instrAddr = RESET_PC; instr_ID = NOP_INSTR; currPC_reg_ID = 0; valid_ID = 0; misalignFault = 0; redirectCount = 0; FSM = BOOT.

FSM states:
- BOOT: first edge after reset release. IF/ID loads NOP_INSTR with valid_ID = 0; PC is not advanced. Always moves to RUN (unless reset), regardless of stall_IF. PCSrc is ignored in BOOT.
- RUN: normal operation, per-edge rules below.

PC update in RUN, priority high to low:
- PCSrc=1: PC <= {calcBranch[63:2], 2'b00}. If calcBranch[1:0] != 0, set misalignFault. redirectCount += 1, holding at all-ones (no wrap).
- stall_IF=1: PC holds.
- Otherwise: PC <= PC + 4, modulo 2^64 (all-ones-minus-3 wraps to 0, no fault).
- PCSrc overrides stall_IF: the branch in EX is older than the stalled instruction.

IF/ID update in RUN, priority high to low:
- IF_ID_flush=1: instr_ID <= NOP_INSTR, valid_ID <= 0. currPC_reg_ID holds. Overrides stall_IF.
- stall_IF=1: instr_ID, currPC_reg_ID and valid_ID hold.
- Otherwise: instr_ID <= instr_IF, currPC_reg_ID <= instrAddr, valid_ID <= 1.

Redirect/flush combinations:
- PCSrc=1 with IF_ID_flush=0 (unconditional/register branch): the IF/ID load is unaffected. Whether to squash is decided upstream.
- IF_ID_flush=1 with PCSrc=0: flush only, PC follows the stall/increment rules.

Latency and output timing:
- instrAddr changes one edge after a redirect. The instruction at the target appears on instr_ID one edge after that.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then release, stall_IF=0, instr_IF=32'h11: first edge gives valid_ID=0, instrAddr=0. Next edges give instrAddr 4, 8 and instr_ID=32'h11, valid_ID=1, currPC_reg_ID=0 then 4.
- At PC=0x10, PCSrc=1, calcBranch=0x1A4, IF_ID_flush=1: next edge gives instrAddr=0x1A4, instr_ID=NOP_INSTR, valid_ID=0, redirectCount=1. Following edge gives currPC_reg_ID=0x1A4, valid_ID=1.
- stall_IF=1 for 3 cycles at PC=0x20: instrAddr stays 0x20 and IF/ID holds. Then PCSrc=1 with stall_IF=1, calcBranch=0x400: instrAddr=0x400 next edge.
- calcBranch=0x3FE with PCSrc=1: instrAddr=0x3FC, misalignFault=1, and it stays 1 through later redirects until reset.
- PC=64'hFFFF_FFFF_FFFF_FFFC, no stall: next instrAddr=0, no fault. With CNT_W=2, 5 redirects give redirectCount=3.
- reset asserted asynchronously mid-cycle during a redirect: outputs go immediately to reset values, and the BOOT bubble is observed after release.
